fetch_slots: RTL

Instruction fetch slot register for the Gambit front end. It holds one fetched bundle of QSLOTS instructions, drives the I-cache fetch address and exposes per-slot valid bits. The valid bits feed the external next-bundle decision. When that decision returns `next`, the block loads the cached bundle and advances the PC. The queue stage drains slots in order, and branch redirects flush the slots.

---
 rtl/gambit_fetch_pkg.sv | 24 ++
 rtl/fetch_stats.sv | 37 +++
 rtl/fetch_slots.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gambit_fetch_pkg.sv
// Shared types and defaults for the Gambit fetch slot register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: fetch FSM state enum, default geometry, reset PC and bundle width helper.
package gambit_fetch_pkg;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;

  localparam int          FETCH_QSLOTS = 2;
  localparam int          FETCH_AWID   = 52;
  localparam int          FETCH_IWID   = 52;
  localparam logic [51:0] FETCH_RSTPC  = 52'hFFFFFFFFFFFE0;

  function automatic int bundle_w(input int qslots, input int iwid);
    return qslots * iwid;
  endfunction

  // Width of one fetched bundle at the default geometry.
  localparam int BUNDLE_W = bundle_w(FETCH_QSLOTS, FETCH_IWID);

endpackage

// File: rtl/fetch_stats.sv
// Load and miss-stall event counters for the fetch slot register.
// Latency: counts are visible one cycle after the pulse.
// Backpressure: none; pulses are sampled every cycle and counters wrap at 2^32.
// Ports: clk, rst_n (sync, active-low), load/stall pulses in, bundle_cnt/stall_cnt out.
module fetch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        stall,
  output logic [31:0] bundle_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] bundle_cnt_q, bundle_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    bundle_cnt_d = bundle_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (load)  bundle_cnt_d = bundle_cnt_q + 32'd1;
    if (stall) stall_cnt_d  = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bundle_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bundle_cnt_q <= bundle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bundle_cnt = bundle_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: rtl/fetch_slots.sv
// Fetch slot register: holds one QSLOTS-wide bundle, drives the I-cache PC, drains slots in order.
// Latency: registered outputs; redirect to first valid slot is 3 cycles (flush, load, valid).
// Backpressure: slots drain only as the queue takes them in order; a miss (!phit) holds ipc.
// Ports: clk, rst_n (sync, active-low); next/phit/ibundle from I-cache side; take from queue;
//        redir/redir_pc from branch unit; ipc/bpc/slotv/insn out.
// Optional: define FETCH_STATS_EN to add bundle_cnt and stall_cnt outputs (fetch_stats counters).
module fetch_slots
  import gambit_fetch_pkg::*;
#(
  parameter int               QSLOTS = FETCH_QSLOTS,
  parameter int               AWID   = FETCH_AWID,
  parameter int               IWID   = FETCH_IWID,
  parameter logic [AWID-1:0]  RSTPC  = AWID'(FETCH_RSTPC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     next,
  input  logic                     phit,
  input  logic [QSLOTS*IWID-1:0]   ibundle,
  input  logic [QSLOTS-1:0]        take,
  input  logic                     redir,
  input  logic [AWID-1:0]          redir_pc,
  output logic [AWID-1:0]          ipc,
  output logic [AWID-1:0]          bpc,
  output logic [QSLOTS-1:0]        slotv,
  output logic [QSLOTS*IWID-1:0]   insn
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              bundle_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int BW = bundle_w(QSLOTS, IWID);

  fetch_state_t       state_q, state_d;
  logic [AWID-1:0]    ipc_q,   ipc_d;
  logic [AWID-1:0]    bpc_q,   bpc_d;
  logic [QSLOTS-1:0]  slotv_q, slotv_d;
  logic [BW-1:0]      insn_q,  insn_d;

  logic               load;
  logic               stall;
  logic [QSLOTS-1:0]  take_hon;
  logic               prefix_ok;

  // In-order drain: slot i may be taken only once every older slot is
  // either already empty or leaving in this same cycle.
  always_comb begin
    take_hon  = '0;
    prefix_ok = 1'b1;
    for (int i = 0; i < QSLOTS; i++) begin
      take_hon[i] = take[i] & slotv_q[i] & prefix_ok;
      prefix_ok   = prefix_ok & (~slotv_q[i] | take[i]);
    end
  end

  // next is ignored while flushing: the I-cache output still reflects the
  // previous ipc, so loading then would capture a stale bundle.
  assign load  = (state_q == ST_FETCH) & next & ~redir;
  assign stall = (state_q == ST_FETCH) & (slotv_q == '0) & ~phit;

  always_comb begin
    state_d = state_q;
    ipc_d   = ipc_q;
    bpc_d   = bpc_q;
    slotv_d = slotv_q;
    insn_d  = insn_q;
    if (redir) begin
      slotv_d = '0;
      ipc_d   = redir_pc;
      state_d = ST_FLUSH;
    end else begin
      if (state_q == ST_FLUSH) state_d = ST_FETCH;
      if (load) begin
        insn_d  = ibundle;
        slotv_d = '1;
        bpc_d   = ipc_q;
        ipc_d   = ipc_q + AWID'(QSLOTS);   // wraps silently at 2^AWID
      end else begin
        slotv_d = slotv_q & ~take_hon;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FLUSH;
      ipc_q   <= RSTPC;
      bpc_q   <= RSTPC;
      slotv_q <= '0;
      insn_q  <= '0;
    end else begin
      state_q <= state_d;
      ipc_q   <= ipc_d;
      bpc_q   <= bpc_d;
      slotv_q <= slotv_d;
      insn_q  <= insn_d;
    end
  end

  assign ipc   = ipc_q;
  assign bpc   = bpc_q;
  assign slotv = slotv_q;
  assign insn  = insn_q;

`ifdef FETCH_STATS_EN
  fetch_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .stall      (stall),
    .bundle_cnt (bundle_cnt),
    .stall_cnt  (stall_cnt)
  );
`else
  // Miss-stall detect only feeds the optional counters.
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule
